// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the next-PC controller: FSM states,
// redirect causes and the PC alignment helper.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        PC_BOOT   = 2'd0,
        PC_RUN    = 2'd1,
        PC_BUBBLE = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_MRET   = 2'd2,
        RD_TRAP   = 2'd3
    } redirect_e;

    localparam logic [31:0] PC_INC16 = 32'd2;
    localparam logic [31:0] PC_INC32 = 32'd4;

    // Instruction addresses are halfword aligned, so bit 0 is always dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_sequencer_next_sel.sv
// Combinational next-PC priority mux: trap > mret > branch > stall > sequential.
// Also decides whether EX advances and what the EX valid bit becomes.
module pc_next_sel
    import pc_seq_pkg::*;
(
    input  logic        active,
    input  logic        accept_ex,
    input  logic        ex_valid,
    input  logic [31:0] pc,
    input  logic        ilen16,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        mret,
    input  logic [31:0] mepc,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    output logic [31:0] pc_next,
    output logic        ex_valid_next,
    output logic        ex_advance,
    output redirect_e   cause
);

    logic [31:0] seq_inc;

    assign seq_inc = ilen16 ? PC_INC16 : PC_INC32;

    // While booting nothing moves; afterwards exactly one source wins.
    always_comb begin
        pc_next       = pc;
        ex_valid_next = ex_valid;
        ex_advance    = 1'b0;
        cause         = RD_NONE;
        if (active) begin
            if (trap_req) begin
                cause         = RD_TRAP;
                pc_next       = align_pc(trap_vector);
                ex_valid_next = 1'b0;
            end else if (mret && accept_ex) begin
                cause         = RD_MRET;
                pc_next       = align_pc(mepc);
                ex_valid_next = 1'b0;
            end else if (br_taken && accept_ex) begin
                cause         = RD_BRANCH;
                pc_next       = align_pc(br_target);
                ex_valid_next = 1'b0;
            end else if (!stall) begin
                pc_next       = align_pc(pc + seq_inc);
                ex_valid_next = 1'b1;
                ex_advance    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the 3-stage core: owns the fetch PC, the EX PC/valid
// and the boot/run/bubble FSM, and reports trap EPC and retirement.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ilen16_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        mret_i,
    input  logic [31:0] mepc_i,
    input  logic        trap_req_i,
    input  logic [31:0] trap_vector_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_ex_o,
    output logic        ex_valid_o,
    output logic        trap_ack_o,
    output logic [31:0] epc_o,
    output logic        retire_o,
    output logic [1:0]  cause_o
);

    pc_state_e   state_q;
    pc_state_e   state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_ex_q;
    logic        ex_valid_q;

    logic [31:0] pc_next;
    logic        ex_valid_next;
    logic        ex_advance;
    redirect_e   cause;
    logic        active;
    logic        accept_ex;

    assign active    = (state_q != PC_BOOT);
    assign accept_ex = ex_valid_q && (state_q == PC_RUN);

    pc_next_sel u_next_sel (
        .active        (active),
        .accept_ex     (accept_ex),
        .ex_valid      (ex_valid_q),
        .pc            (pc_q),
        .ilen16        (ilen16_i),
        .stall         (stall_i),
        .br_taken      (br_taken_i),
        .br_target     (br_target_i),
        .mret          (mret_i),
        .mepc          (mepc_i),
        .trap_req      (trap_req_i),
        .trap_vector   (trap_vector_i),
        .pc_next       (pc_next),
        .ex_valid_next (ex_valid_next),
        .ex_advance    (ex_advance),
        .cause         (cause)
    );

    // Every redirect is followed by one bubble; a stall freezes the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_BOOT: state_d = PC_RUN;
            PC_RUN, PC_BUBBLE: begin
                if (cause != RD_NONE) begin
                    state_d = PC_BUBBLE;
                end else if (!stall_i) begin
                    state_d = PC_RUN;
                end
            end
            default: state_d = PC_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PC_BOOT;
            pc_q       <= RESET_VECTOR;
            pc_ex_q    <= RESET_VECTOR;
            ex_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_next;
            ex_valid_q <= ex_valid_next;
            if (ex_advance) begin
                pc_ex_q <= pc_q;
            end
        end
    end

    // A trap with no valid EX instruction resumes at the fetch PC instead.
    assign trap_ack_o = (cause == RD_TRAP);
    assign epc_o      = (trap_ack_o && !ex_valid_q) ? pc_q : pc_ex_q;
    assign retire_o   = ex_valid_q & ~stall_i & ~trap_req_i;
    assign cause_o    = cause;

    assign pc_o       = pc_q;
    assign pc_ex_o    = pc_ex_q;
    assign ex_valid_o = ex_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table, a mid-redirect
// reset sequence and randomized cycles checked against a behavioural model.
module tb_pc_sequencer;

    localparam logic [1:0] C_NONE   = 2'd0;
    localparam logic [1:0] C_BRANCH = 2'd1;
    localparam logic [1:0] C_MRET   = 2'd2;
    localparam logic [1:0] C_TRAP   = 2'd3;

    typedef struct {
        bit          ilen16;
        bit          stall;
        bit          br;
        bit          mret;
        bit          trap;
        logic [31:0] target;
        logic [31:0] mepc;
        logic [31:0] vec;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          ack;
        logic [31:0] epc;
        bit          retire;
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] pc_ex;
        bit          valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ilen16_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        mret_i = 1'b0;
    logic [31:0] mepc_i = '0;
    logic        trap_req_i = 1'b0;
    logic [31:0] trap_vector_i = '0;
    logic [31:0] pc_o;
    logic [31:0] pc_ex_o;
    logic        ex_valid_o;
    logic        trap_ack_o;
    logic [31:0] epc_o;
    logic        retire_o;
    logic [1:0]  cause_o;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of fetch/EX, not the FSM encoding.
    logic [31:0] m_pc;
    logic [31:0] m_pc_ex;
    bit          m_valid;
    bit          m_booting;
    stim_t       cur;
    vec_t        table_q[$];

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .ilen16_i      (ilen16_i),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .mret_i        (mret_i),
        .mepc_i        (mepc_i),
        .trap_req_i    (trap_req_i),
        .trap_vector_i (trap_vector_i),
        .pc_o          (pc_o),
        .pc_ex_o       (pc_ex_o),
        .ex_valid_o    (ex_valid_o),
        .trap_ack_o    (trap_ack_o),
        .epc_o         (epc_o),
        .retire_o      (retire_o),
        .cause_o       (cause_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(bit ilen16, bit stall, bit br, bit mret, bit trap,
                                 logic [31:0] target, logic [31:0] mepc, logic [31:0] vec);
        stim_t s;
        s.ilen16 = ilen16; s.stall = stall; s.br = br; s.mret = mret; s.trap = trap;
        s.target = target; s.mepc = mepc; s.vec = vec;
        return s;
    endfunction

    task automatic addVec(input stim_t s, input bit ack, input logic [31:0] epc, input bit retire,
                          input logic [1:0] cause, input logic [31:0] pc,
                          input logic [31:0] pc_ex, input bit valid);
        vec_t v;
        v.s = s; v.ack = ack; v.epc = epc; v.retire = retire; v.cause = cause;
        v.pc = pc; v.pc_ex = pc_ex; v.valid = valid;
        table_q.push_back(v);
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] modelCause();
        if (m_booting) return C_NONE;
        if (cur.trap) return C_TRAP;
        if (m_valid && cur.mret) return C_MRET;
        if (m_valid && cur.br) return C_BRANCH;
        return C_NONE;
    endfunction

    task automatic modelReset();
        m_pc = 32'h0; m_pc_ex = 32'h0; m_valid = 1'b0; m_booting = 1'b1;
    endtask

    task automatic modelStep();
        logic [1:0] c;
        c = modelCause();
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (c == C_TRAP) begin
            m_pc = cur.vec & 32'hFFFF_FFFE; m_valid = 1'b0;
        end else if (c == C_MRET) begin
            m_pc = cur.mepc & 32'hFFFF_FFFE; m_valid = 1'b0;
        end else if (c == C_BRANCH) begin
            m_pc = cur.target & 32'hFFFF_FFFE; m_valid = 1'b0;
        end else if (!cur.stall) begin
            m_pc_ex = m_pc;
            m_valid = 1'b1;
            m_pc = m_pc + (cur.ilen16 ? 32'd2 : 32'd4);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur = s;
        ilen16_i = s.ilen16; stall_i = s.stall; br_taken_i = s.br; br_target_i = s.target;
        mret_i = s.mret; mepc_i = s.mepc; trap_req_i = s.trap; trap_vector_i = s.vec;
        #1;
    endtask

    task automatic checkOutput();
        logic [1:0] c;
        c = modelCause();
        checkVal("pc", pc_o, m_pc);
        checkVal("pc_ex", pc_ex_o, m_pc_ex);
        checkVal("ex_valid", {31'b0, ex_valid_o}, {31'b0, m_valid});
        checkVal("cause", {30'b0, cause_o}, {30'b0, c});
        checkVal("trap_ack", {31'b0, trap_ack_o}, {31'b0, c == C_TRAP});
        checkVal("epc", epc_o, (c == C_TRAP && !m_valid) ? m_pc : m_pc_ex);
        checkVal("retire", {31'b0, retire_o}, {31'b0, m_valid && !cur.stall && !cur.trap});
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, "_pc"}, pc_o, 32'h0);
        checkVal({tag, "_pc_ex"}, pc_ex_o, 32'h0);
        checkVal({tag, "_valid"}, {31'b0, ex_valid_o}, 32'h0);
        checkVal({tag, "_ack"}, {31'b0, trap_ack_o}, 32'h0);
        checkVal({tag, "_retire"}, {31'b0, retire_o}, 32'h0);
        checkVal({tag, "_cause"}, {30'b0, cause_o}, {30'b0, C_NONE});
    endtask

    initial begin
        stim_t s;
        cur = st(0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("por");
        reset = 1'b0;

        // Boot ignores requests, then sequential with alternating lengths.
        addVec(st(0,0,1,1,1, 32'h40, 32'h50, 32'h60), 0, 32'h0,   0, C_NONE,   32'h0,   32'h0,   0);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'h0,   0, C_NONE,   32'h4,   32'h0,   1);
        addVec(st(1,0,0,0,0, 0, 0, 0),                0, 32'h0,   1, C_NONE,   32'h6,   32'h4,   1);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'h4,   1, C_NONE,   32'hA,   32'h6,   1);
        addVec(st(1,0,0,0,0, 0, 0, 0),                0, 32'h6,   1, C_NONE,   32'hC,   32'hA,   1);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'hA,   1, C_NONE,   32'h10,  32'hC,   1);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'hC,   1, C_NONE,   32'h14,  32'h10,  1);
        addVec(st(0,0,1,0,0, 32'h101, 0, 0),          0, 32'h10,  1, C_BRANCH, 32'h100, 32'h10,  0);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'h10,  0, C_NONE,   32'h104, 32'h100, 1);
        addVec(st(0,1,0,0,0, 0, 0, 0),                0, 32'h100, 0, C_NONE,   32'h104, 32'h100, 1);
        addVec(st(1,1,0,0,0, 0, 0, 0),                0, 32'h100, 0, C_NONE,   32'h104, 32'h100, 1);
        addVec(st(0,1,0,0,0, 0, 0, 0),                0, 32'h100, 0, C_NONE,   32'h104, 32'h100, 1);
        addVec(st(1,0,0,0,0, 0, 0, 0),                0, 32'h100, 1, C_NONE,   32'h106, 32'h104, 1);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'h104, 1, C_NONE,   32'h10A, 32'h106, 1);
        addVec(st(0,0,1,0,0, 32'h20, 0, 0),           0, 32'h106, 1, C_BRANCH, 32'h20,  32'h106, 0);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'h106, 0, C_NONE,   32'h24,  32'h20,  1);
        // Trap beats a simultaneous branch and reports the branching instruction.
        addVec(st(0,0,1,0,1, 32'h300, 0, 32'h80),     1, 32'h20,  0, C_TRAP,   32'h80,  32'h20,  0);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'h20,  0, C_NONE,   32'h84,  32'h80,  1);
        addVec(st(0,0,1,0,0, 32'h100, 0, 0),          0, 32'h80,  1, C_BRANCH, 32'h100, 32'h80,  0);
        addVec(st(0,0,0,1,1, 0, 32'h200, 32'h80),     1, 32'h100, 0, C_TRAP,   32'h80,  32'h80,  0);
        addVec(st(0,0,0,1,0, 0, 32'h200, 0),          0, 32'h80,  0, C_NONE,   32'h84,  32'h80,  1);
        addVec(st(0,0,0,1,0, 0, 32'h100, 0),          0, 32'h80,  1, C_MRET,   32'h100, 32'h80,  0);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'h80,  0, C_NONE,   32'h104, 32'h100, 1);
        // Address wrap at the top of the space.
        addVec(st(0,0,1,0,0, 32'hFFFF_FFFC, 0, 0),    0, 32'h100, 1, C_BRANCH, 32'hFFFF_FFFC, 32'h100, 0);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'h100, 0, C_NONE,   32'h0,   32'hFFFF_FFFC, 1);
        addVec(st(1,0,0,0,0, 0, 0, 0),                0, 32'hFFFF_FFFC, 1, C_NONE, 32'h2, 32'h0, 1);
        addVec(st(0,0,1,0,0, 32'hFFFF_FFFF, 0, 0),    0, 32'h0,   1, C_BRANCH, 32'hFFFF_FFFE, 32'h0, 0);
        addVec(st(1,0,0,0,0, 0, 0, 0),                0, 32'h0,   0, C_NONE,   32'h0,   32'hFFFF_FFFE, 1);
        addVec(st(0,1,0,0,1, 0, 0, 32'h41),           1, 32'hFFFF_FFFE, 0, C_TRAP, 32'h40, 32'hFFFF_FFFE, 0);
        addVec(st(0,0,0,0,0, 0, 0, 0),                0, 32'hFFFF_FFFE, 0, C_NONE, 32'h44, 32'h40, 1);

        foreach (table_q[i]) begin
            applyStimulus(table_q[i].s);
            checkOutput();
            checkVal($sformatf("v%0d_ack", i), {31'b0, trap_ack_o}, {31'b0, table_q[i].ack});
            checkVal($sformatf("v%0d_epc", i), epc_o, table_q[i].epc);
            checkVal($sformatf("v%0d_retire", i), {31'b0, retire_o}, {31'b0, table_q[i].retire});
            checkVal($sformatf("v%0d_cause", i), {30'b0, cause_o}, {30'b0, table_q[i].cause});
            clockEdge();
            checkVal($sformatf("v%0d_pc", i), pc_o, table_q[i].pc);
            checkVal($sformatf("v%0d_pc_ex", i), pc_ex_o, table_q[i].pc_ex);
            checkVal($sformatf("v%0d_valid", i), {31'b0, ex_valid_o}, {31'b0, table_q[i].valid});
        end

        // Reset in the middle of a branch cycle aborts it immediately.
        applyStimulus(st(0,0,1,0,0, 32'h500, 0, 0));
        checkVal("mid_cause_pre", {30'b0, cause_o}, {30'b0, C_BRANCH});
        #2 reset = 1'b1;
        #1;
        checkResetValues("mid");
        @(posedge clk);
        #1;
        checkVal("mid_hold_pc", pc_o, 32'h0);
        reset = 1'b0;
        modelReset();
        applyStimulus(st(0,0,0,0,0, 0, 0, 0));
        checkOutput();
        clockEdge();
        checkVal("reboot_pc", pc_o, 32'h0);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 600; n++) begin
            s.ilen16 = $urandom_range(0, 1);
            s.stall  = ($urandom_range(0, 99) < 20);
            s.br     = ($urandom_range(0, 99) < 15);
            s.mret   = ($urandom_range(0, 99) < 8);
            s.trap   = ($urandom_range(0, 99) < 7);
            s.target = $urandom;
            s.mepc   = $urandom;
            s.vec    = $urandom;
            applyStimulus(s);
            checkOutput();
            if ($urandom_range(0, 99) < 2) begin
                #2 reset = 1'b1;
                #1;
                modelReset();
                checkOutput();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else begin
                clockEdge();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 3-stage core. Owns the fetch PC and the PC/valid of the instruction in EX. Each cycle it picks exactly one next-PC source: sequential (+2 compressed / +4), branch/jump target, trap vector, mret return or hold. It flushes the wrong-path instruction after every redirect and supplies the trap EPC to the CSR unit.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- ilen16_i  in  1  instruction at pc_o is compressed (inst[1:0] != 2'b11)
- stall_i  in  1  hold fetch and EX (memory wait)
- br_taken_i  in  1  EX-stage branch/jump taken
- br_target_i  in  32  ALU-computed target
- mret_i  in  1  EX-stage instruction is mret
- mepc_i  in  32  return address from CSR file
- trap_req_i  in  1  exception/interrupt request from CSR unit
- trap_vector_i  in  32  handler address (mtvec-derived)
- pc_o  out  32  fetch PC (registered)
- pc_ex_o  out  32  PC of EX-stage instruction (registered)
- ex_valid_o  out  1  EX-stage instruction is valid (registered)
- trap_ack_o  out  1  trap accepted this cycle (combinational)
- epc_o  out  32  PC to write into mepc while trap_ack_o=1
- retire_o  out  1  EX instruction completes this cycle
- cause_o  out  2  redirect source this cycle (redirect_e)

## Operation
- FSM states:
  - PC_BOOT: one cycle after reset release. Holds pc_o and ignores all requests. Always goes to PC_RUN.
  - PC_RUN: normal advance.
  - PC_BUBBLE: the cycle after a redirect. ex_valid_o=0. Trap is still accepted; branch and mret are ignored. Next state is PC_RUN, or PC_BUBBLE if a trap is taken.
- Priority in RUN/BUBBLE is trap > mret > branch > stall > sequential.
- mret and branch count only when ex_valid_o=1.
- Trap: trap_ack_o=1, cause RD_TRAP.
  - epc_o = pc_ex_o if ex_valid_o, otherwise pc_o.
  - Edge: pc_o<=trap_vector_i, ex_valid_o<=0, state to PC_BUBBLE.
  - Trap overrides stall_i.
- mret: pc_o<=mepc_i, ex_valid_o<=0, cause RD_MRET, state to PC_BUBBLE.
- Branch: pc_o<=br_target_i, ex_valid_o<=0, cause RD_BRANCH, state to PC_BUBBLE.
- Stall (no redirect): pc_o, pc_ex_o, ex_valid_o and state all hold. retire_o=0.
- Sequential: pc_ex_o<=pc_o, ex_valid_o<=1, pc_o<=pc_o+(ilen16_i?2:4).
- Arithmetic: all targets have bit0 forced to 0. Addition wraps modulo 2^32 (32'hFFFF_FFFE+2 = 0).
- retire_o = ex_valid_o & ~stall_i & ~trap_req_i. A taken branch or mret does retire.
- Outside a trap cycle, epc_o = pc_ex_o.

## Timing
- Reset, asynchronous:
  - pc_o = pc_ex_o = RESET_VECTOR
  - ex_valid_o = 0, state PC_BOOT
  - trap_ack_o = retire_o = 0, cause_o = RD_NONE
- A reset asserted mid-operation aborts any redirect immediately. No pending request survives reset.
- Redirect latency: request at edge N means pc_o = target after edge N. Exactly one bubble follows (ex_valid_o=0 for the cycle after edge N).
- Boot: first valid EX instruction (pc_ex_o=RESET_VECTOR) appears 2 edges after reset release.
- trap_ack_o, epc_o, retire_o and cause_o are combinational from the current state and inputs. They are valid in the same cycle as the request.
- Simultaneous trap+branch or trap+mret: the trap wins, and epc_o = pc_ex_o (the branching instruction).

## Structure
- Package pc_seq_pkg:
  - pc_state_e {PC_BOOT, PC_RUN, PC_BUBBLE}
  - redirect_e {RD_NONE, RD_BRANCH, RD_MRET, RD_TRAP}
  - constants PC_INC16=2, PC_INC32=4
- Sub-module pc_next_sel: combinational priority mux. Produces next-PC, cause and the ex_valid next value. The top module holds the FSM and registers.

## Test plan
- Reset release, no stall, ilen16 alternating 0,1 from RESET_VECTOR=0:
  - pc_o holds 0 for one cycle, then 4, then 6.
  - ex_valid_o first rises with pc_ex_o=0.
- Branch at pc_ex_o=0x10, target 0x101 → pc_o=0x100, ex_valid_o=0 for 1 cycle, retire_o=1, cause_o=RD_BRANCH.
- Stall for 3 cycles with ex_valid_o=1 → pc_o, pc_ex_o and ex_valid_o unchanged; retire_o=0 throughout.
- trap_req_i with br_taken_i, pc_ex_o=0x20, vector 0x80 → trap_ack_o=1, epc_o=0x20, pc_o=0x80 next cycle.
- trap_req_i in PC_BUBBLE (pc_o=0x100) → epc_o=0x100. mret_i there is ignored. Later mret with mepc_i=0x100 → pc_o=0x100.
- pc_o=0xFFFF_FFFC, ilen16=0 → pc_o=0. Asserting reset mid-redirect → outputs return to reset values immediately.
